// File: rtl/cycle_uart_in.sv
// UART receiver: 2-flop synchronizer, framing FSM, byte-to-word joiner and show-ahead word FIFO.
// Optional 8E1 parity checking is enabled by defining CYCLE_UART_IN_PARITY_EN.
`default_nettype none

module cycle_uart_in #(
    parameter int WORD_SIZE = 32,
    parameter int WORD_PART = 8,
    parameter int MEM_SIZE  = 64,
    parameter int CLQ_FREQ  = 200_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sig,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 full,
    output logic                 empty,
    output logic                 frame_err,
    output logic                 overflow
);

    localparam int CLKS_PER_BIT = CLQ_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int NUM_PARTS    = WORD_SIZE / WORD_PART;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W        = (WORD_PART > 1) ? $clog2(WORD_PART) : 1;
    localparam int PART_W       = (NUM_PARTS > 1) ? $clog2(NUM_PARTS) : 1;
    localparam int ADDR_W       = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF   = CNT_W'(HALF_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(WORD_PART - 1);
    localparam logic [PART_W-1:0] PART_LAST  = PART_W'(NUM_PARTS - 1);
    localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W + 1)'(MEM_SIZE);

    typedef enum logic [2:0] {
        ST_ARM,
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef CYCLE_UART_IN_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    logic                 sig_meta_q, sig_meta_d;
    logic                 sig_s_q, sig_s_d;
    logic                 sig_prev_q, sig_prev_d;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
    logic [WORD_PART-1:0] shift_q, shift_d;
    logic                 byte_stb_q, byte_stb_d;
    logic                 ferr_q, ferr_d;

    logic [PART_W-1:0]    part_q, part_d;
    logic [WORD_SIZE-1:0] word_q, word_d;
    logic                 push_q, push_d;

    logic [WORD_SIZE-1:0] mem_q [MEM_SIZE];
    logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]      count_q, count_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 ovf_q, ovf_d;
    logic [WORD_SIZE-1:0] data_q, data_d;

    logic                 do_pop;
    logic                 do_push;
    logic [ADDR_W:0]      remain;

    always_comb begin
        sig_meta_d = sig;
        sig_s_d    = sig_meta_q;
        sig_prev_d = sig_s_q;
    end

    // Receive FSM; every bit period is timed from the start-bit midpoint.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_stb_d = 1'b0;
        ferr_d     = 1'b0;

        case (state_q)
            ST_ARM: begin
                if (!sig_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_IDLE: begin
                if (sig_prev_q && !sig_s_q) begin
                    cnt_d   = '0;
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = sig_s_q ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = WORD_PART'({sig_s_q, shift_q} >> 1);
                    if (bit_idx_q == BIT_LAST) begin
`ifdef CYCLE_UART_IN_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

`ifdef CYCLE_UART_IN_PARITY_EN
            // Even parity: data bits plus parity bit must XOR to zero.
            ST_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (^{shift_q, sig_s_q}) begin
                        ferr_d  = 1'b1;
                        state_d = ST_ARM;
                    end else begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif

            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (sig_s_q) begin
                        byte_stb_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_ARM;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_ARM;
            end
        endcase
    end

    // First byte of a word ends up in the most significant part after the shifts.
    always_comb begin
        word_d = word_q;
        part_d = part_q;
        push_d = 1'b0;

        if (ferr_q) begin
            word_d = '0;
            part_d = '0;
        end else if (byte_stb_q) begin
            word_d = (word_q << WORD_PART) | WORD_SIZE'(shift_q);
            if (part_q == PART_LAST) begin
                part_d = '0;
                push_d = 1'b1;
            end else begin
                part_d = part_q + 1'b1;
            end
        end
    end

    always_comb begin
        do_pop   = !empty_q && ready_in;
        do_push  = push_q && (!full_q || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (push_q && !do_push);
        data_d   = data_q;

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        full_d  = (count_d == COUNT_FULL);
        empty_d = (count_d == '0);

        // Show-ahead head register; a push into an otherwise empty FIFO bypasses the memory.
        remain = count_q - {{ADDR_W{1'b0}}, do_pop};
        if (count_d != '0) begin
            if (remain == '0) begin
                data_d = word_q;
            end else begin
                data_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= word_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sig_meta_q <= 1'b1;
            sig_s_q    <= 1'b1;
            sig_prev_q <= 1'b1;
            state_q    <= ST_ARM;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            byte_stb_q <= 1'b0;
            ferr_q     <= 1'b0;
            part_q     <= '0;
            word_q     <= '0;
            push_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ovf_q      <= 1'b0;
            data_q     <= '0;
        end else begin
            sig_meta_q <= sig_meta_d;
            sig_s_q    <= sig_s_d;
            sig_prev_q <= sig_prev_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            byte_stb_q <= byte_stb_d;
            ferr_q     <= ferr_d;
            part_q     <= part_d;
            word_q     <= word_d;
            push_q     <= push_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            ovf_q      <= ovf_d;
            data_q     <= data_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = !empty_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign frame_err = ferr_q;
    assign overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_cycle_uart_in.sv
// Bench for cycle_uart_in at 10 clocks/bit and a 4-word FIFO; parity cases follow CYCLE_UART_IN_PARITY_EN.
module tb_cycle_uart_in;

    localparam int WS   = 32;
    localparam int MEM  = 4;
    localparam int CPB  = 10;
`ifdef CYCLE_UART_IN_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // Start bit driven in cycle k: sig_s low at k+2, START at k+3, midpoint at k+7,
    // then data, optional parity and stop bits one bit time apart.
    localparam int STOP_T = 7 + CPB * (9 + PAR_BITS);

    localparam int GOOD     = 0;
    localparam int BAD_STOP = 1;
    localparam int BAD_PAR  = 2;

    logic          clock;
    logic          reset;
    logic          sig;
    logic [WS-1:0] data_out;
    logic          valid_out;
    logic          ready_in;
    logic          full;
    logic          empty;
    logic          frame_err;
    logic          overflow;

    cycle_uart_in #(
        .WORD_SIZE(WS),
        .WORD_PART(8),
        .MEM_SIZE (MEM),
        .CLQ_FREQ (1_000_000),
        .BAUD_RATE(100_000)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .sig      (sig),
        .data_out (data_out),
        .valid_out(valid_out),
        .ready_in (ready_in),
        .full     (full),
        .empty    (empty),
        .frame_err(frame_err),
        .overflow (overflow)
    );

    typedef struct packed {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
        logic [31:0] exp_word;
    } vec_t;

    vec_t        vecs [5];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] got_q [$];
    int          rise_cyc = 0;
    int          rise_cnt = 0;
    int          ferr_cnt = 0;
    int          ferr_cyc = 0;
    logic        valid_prev = 1'b0;
    logic        ready_cmd = 1'b0;
    logic        rand_ready = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        ready_in = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            if (rand_ready) ready_in = 1'($urandom_range(0, 1));
            else            ready_in = ready_cmd;
        end
    end

    always @(negedge clock) begin
        if (valid_out && ready_in) got_q.push_back(data_out);
        if (valid_out && !valid_prev) begin
            rise_cyc = cyc;
            rise_cnt = rise_cnt + 1;
        end
        valid_prev = valid_out;
        if (frame_err) begin
            ferr_cnt = ferr_cnt + 1;
            ferr_cyc = cyc;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors = vectors + 1;
        if (actual !== expected) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int mode, output int start_cyc);
        sig       = 1'b0;
        start_cyc = cyc;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            sig = b[i];
            tick(CPB);
        end
`ifdef CYCLE_UART_IN_PARITY_EN
        sig = (^b) ^ (mode == BAD_PAR);
        tick(CPB);
`endif
        sig = (mode != BAD_STOP);
        tick(CPB);
        sig = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w, output int last_start);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(w[31 - 8*i -: 8], GOOD, last_start);
        end
    endtask

    task automatic expect_word(input string name, input logic [31:0] exp_w);
        logic [31:0] w;
        if (got_q.size() == 0) begin
            vectors     = vectors + 1;
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got no word, expected 0x%08h", name, exp_w);
        end else begin
            w = got_q.pop_front();
            checkOutput(name, 64'(w), 64'(exp_w));
        end
    endtask

    initial begin
        int          s;
        int          f0;
        int          r0;
        logic [31:0] w;
        logic [7:0]  b;
        logic [31:0] model_q [$];
        logic [31:0] exp_q [$];
        logic [7:0]  partial [$];
        bit          model_ovf;
        bit          bad;

        vecs[0] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hDEADBEEF};
        vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFFFFFF};
        vecs[3] = '{8'h01, 8'h80, 8'h7F, 8'h55, 32'h01807F55};
        vecs[4] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 32'hA55AC33C};

        sig   = 1'b1;
        reset = 1'b1;
        tick(4);
        checkOutput("rst_valid", 64'(valid_out), 64'(0));
        checkOutput("rst_empty", 64'(empty), 64'(1));
        checkOutput("rst_full", 64'(full), 64'(0));
        checkOutput("rst_frame_err", 64'(frame_err), 64'(0));
        checkOutput("rst_overflow", 64'(overflow), 64'(0));
        checkOutput("rst_data_out", 64'(data_out), 64'(0));
        reset = 1'b0;
        tick(20);

        // Table: back-to-back bytes, consumer always ready.
        ready_cmd = 1'b1;
        tick(2);
        for (int v = 0; v < 5; v++) begin
            got_q.delete();
            r0 = rise_cnt;
            applyStimulus(vecs[v].b0, GOOD, s);
            applyStimulus(vecs[v].b1, GOOD, s);
            applyStimulus(vecs[v].b2, GOOD, s);
            applyStimulus(vecs[v].b3, GOOD, s);
            tick(6);
            checkOutput($sformatf("vec%0d_latency", v), 64'(rise_cyc - s), 64'(STOP_T + 3));
            checkOutput($sformatf("vec%0d_beats", v), 64'(rise_cnt - r0), 64'(1));
            checkOutput($sformatf("vec%0d_pops", v), 64'(got_q.size()), 64'(1));
            expect_word($sformatf("vec%0d_word", v), vecs[v].exp_word);
            checkOutput($sformatf("vec%0d_empty", v), 64'(empty), 64'(1));
        end

        // Overflow: five words into a four-word FIFO with no consumer.
        ready_cmd = 1'b0;
        tick(2);
        got_q.delete();
        model_q.delete();
        model_ovf = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w = $urandom();
            if (model_q.size() < MEM) model_q.push_back(w);
            else                      model_ovf = 1'b1;
            send_word(w, s);
            tick(3);
            if (i == 3) begin
                checkOutput("ovf_full_after_4", 64'(full), 64'(model_q.size() == MEM));
                checkOutput("ovf_flag_after_4", 64'(overflow), 64'(model_ovf));
            end
        end
        checkOutput("ovf_flag_after_5", 64'(overflow), 64'(model_ovf));
        checkOutput("ovf_full_after_5", 64'(full), 64'(1));
        ready_cmd = 1'b1;
        tick(10);
        checkOutput("ovf_drain_count", 64'(got_q.size()), 64'(model_q.size()));
        while (model_q.size() > 0) expect_word("ovf_drain_word", model_q.pop_front());
        checkOutput("ovf_drain_empty", 64'(empty), 64'(1));
        checkOutput("ovf_drain_full", 64'(full), 64'(0));
        checkOutput("ovf_sticky", 64'(overflow), 64'(1));
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        checkOutput("ovf_cleared_by_reset", 64'(overflow), 64'(0));
        tick(20);

        // Bad stop bit drops the byte and the partial word.
        got_q.delete();
        f0 = ferr_cnt;
        applyStimulus(8'h11, GOOD, s);
        applyStimulus(8'h22, BAD_STOP, s);
        tick(20);
        checkOutput("ferr_pulses", 64'(ferr_cnt - f0), 64'(1));
        checkOutput("ferr_cycle", 64'(ferr_cyc - s), 64'(STOP_T + 1));
        send_word(32'h33445566, s);
        tick(6);
        checkOutput("ferr_words", 64'(got_q.size()), 64'(1));
        expect_word("ferr_word", 32'h33445566);
        checkOutput("ferr_no_more", 64'(ferr_cnt - f0), 64'(1));

        // Short low glitch on an idle line.
        got_q.delete();
        f0 = ferr_cnt;
        r0 = rise_cnt;
        sig = 1'b0;
        tick(3);
        sig = 1'b1;
        tick(30);
        checkOutput("glitch_ferr", 64'(ferr_cnt - f0), 64'(0));
        checkOutput("glitch_valid", 64'(rise_cnt - r0), 64'(0));
        checkOutput("glitch_empty", 64'(empty), 64'(1));
        send_word(32'h0F1E2D3C, s);
        tick(6);
        expect_word("glitch_next_word", 32'h0F1E2D3C);

        // Reset in the middle of the second byte, line still low at release.
        got_q.delete();
        f0 = ferr_cnt;
        applyStimulus(8'h12, GOOD, s);
        sig = 1'b0;
        tick(15);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        r0 = rise_cnt;
        tick(30);
        checkOutput("rstmid_ferr", 64'(ferr_cnt - f0), 64'(0));
        checkOutput("rstmid_valid", 64'(rise_cnt - r0), 64'(0));
        checkOutput("rstmid_empty", 64'(empty), 64'(1));
        sig = 1'b1;
        tick(20);
        send_word(32'hCAFEF00D, s);
        tick(6);
        checkOutput("rstmid_words", 64'(got_q.size()), 64'(1));
        expect_word("rstmid_word", 32'hCAFEF00D);

`ifdef CYCLE_UART_IN_PARITY_EN
        got_q.delete();
        f0 = ferr_cnt;
        applyStimulus(8'h01, BAD_PAR, s);
        tick(20);
        checkOutput("par_bad_pulse", 64'(ferr_cnt - f0), 64'(1));
        checkOutput("par_bad_cycle", 64'(ferr_cyc - s), 64'(STOP_T - CPB + 1));
        send_word(32'h01020304, s);
        tick(6);
        checkOutput("par_good_words", 64'(got_q.size()), 64'(1));
        expect_word("par_good_word", 32'h01020304);
`endif

        // Random bytes, occasional bad stop bits, random consumer stalls.
        got_q.delete();
        exp_q.delete();
        partial.delete();
        rand_ready = 1'b1;
        for (int i = 0; i < 48; i++) begin
            b   = 8'($urandom());
            bad = ($urandom_range(0, 9) == 0);
            applyStimulus(b, bad ? BAD_STOP : GOOD, s);
            if (bad) begin
                partial.delete();
                tick(2 * CPB);
            end else begin
                partial.push_back(b);
                if (partial.size() == 4) begin
                    exp_q.push_back({partial[0], partial[1], partial[2], partial[3]});
                    partial.delete();
                end
            end
            tick($urandom_range(0, 3));
        end
        tick(6);
        rand_ready = 1'b0;
        ready_cmd  = 1'b1;
        tick(10 + MEM);
        checkOutput("rand_count", 64'(got_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0) expect_word("rand_word", exp_q.pop_front());
        checkOutput("rand_empty", 64'(empty), 64'(1));
        checkOutput("rand_overflow", 64'(overflow), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cycle_uart_in.md
# cycle_uart_in

Receive-side counterpart of the 32-bit-word UART transmit path. Samples the serial line `sig`, recovers 8-bit frames (8N1), joins each group of `WORD_SIZE/WORD_PART` consecutive bytes into one word, and buffers complete words in an internal FIFO. The FIFO is read through a valid/ready handshake. Sits between the board RX pin and any word-oriented consumer in the design.

## Interface
Parameters:
- `WORD_SIZE`, 32: assembled word width; must be a multiple of `WORD_PART`.
- `WORD_PART`, 8: UART frame data width.
- `MEM_SIZE`, 64: FIFO depth in words; power of two.
- `CLQ_FREQ`, 200_000_000: clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate. `CLKS_PER_BIT = CLQ_FREQ/BAUD_RATE` (integer divide; 1736 at defaults).

Ports:
- `clock`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `sig`  in  1  asynchronous serial line; idle high.
- `data_out`  out  WORD_SIZE  FIFO head word.
- `valid_out`  out  1  `data_out` holds a valid word.
- `ready_in`  in  1  consumer accepts the head word.
- `full`  out  1  FIFO holds `MEM_SIZE` words.
- `empty`  out  1  FIFO holds 0 words.
- `frame_err`  out  1  one-cycle pulse on a bad stop bit (or a parity error, see Configuration).
- `overflow`  out  1  sticky; a word was dropped because the FIFO was full. Cleared only by reset.

## Operation
- `sig` passes through a 2-flop synchronizer (`sig_s`) before any use.
- RX FSM states are IDLE, START, DATA, PARITY (macro only), STOP, and ARM.
- ARM: entered from reset. Waits until `sig_s` has been high for one full `CLKS_PER_BIT`, then goes to IDLE. This prevents locking onto a frame that was already in progress.
- IDLE: a falling edge on `sig_s` loads the bit counter and moves to START.
- START: at `CLKS_PER_BIT/2`, if `sig_s`=0 go to DATA. Otherwise treat it as a glitch and return to IDLE with no error.
- DATA: sample every `CLKS_PER_BIT` from the start-bit midpoint. Data is LSB first, `WORD_PART` bits.
- STOP: sample one bit time later.
  - `sig_s`=1: raise the internal byte strobe.
  - `sig_s`=0: pulse `frame_err`, drop the byte, clear the partial word, and go to ARM.
- Joiner:
  - Part counter runs 0..`WORD_SIZE/WORD_PART-1`.
  - The first received byte lands in the MS part (bits [31:24] at defaults); the last lands in bits [7:0].
  - The counter wraps after the final part and issues one push.
- FIFO:
  - Show-ahead; `data_out` is the head word whenever `valid_out`=1.
  - Pop on `valid_out && ready_in`.
  - Push while `full`=1 succeeds only if a pop happens in the same cycle. Otherwise the word is discarded and `overflow` is set.
  - Push and pop together when empty: the pop is not possible (`valid_out`=0) and the push succeeds.
- `valid_out` = ~`empty`. `data_out` is undefined-but-stable when empty; it holds its last value.
- Reset values:
  - `valid_out`=0, `empty`=1, `full`=0, `frame_err`=0, `overflow`=0, `data_out`=0.
  - FSM is in ARM; part counter and FIFO pointers are 0.
- Reset mid-frame discards all partial state and all buffered words.

## Timing
- Stop-bit sample in cycle T:
  - byte strobe in T+1;
  - on the last part, FIFO write in T+2;
  - `valid_out` high in T+3.
- Start-to-strobe: about 9.5 bit times plus 2 synchronizer cycles.
- `frame_err` is high for exactly one cycle: T+1.
- A pop updates `data_out`/`valid_out` in the next cycle; back-to-back pops give one word per cycle.
- `full`/`empty` update in the cycle after the push or pop that changes occupancy.
- The line can run back-to-back frames (stop bit followed immediately by a start bit) with no loss. The FSM re-enters IDLE at the stop midpoint.

## Configuration
- `CYCLE_UART_IN_PARITY_EN` defined:
  - Frames are 8E1, and the PARITY state samples one bit after the data bits.
  - The XOR of the data and parity bits must be 0. A mismatch pulses `frame_err`, drops the byte, clears the partial word, and goes to ARM.
  - Stop-bit check still applies.
- Not defined: frames are 8N1 and the PARITY state and its logic are absent.

## Test plan
Benches use `CLQ_FREQ`=1_000_000 and `BAUD_RATE`=100_000, giving 10 clocks/bit, with `MEM_SIZE`=4.
- Send bytes 0xDE, 0xAD, 0xBE, 0xEF with `ready_in`=1 -> exactly one `valid_out` beat with `data_out`=0xDEADBEEF, 3 cycles after the 4th stop sample.
- Send 5 words with `ready_in`=0 -> `full`=1 after the 4th word, the 5th word is dropped, `overflow`=1. Then drain -> 4 words in order, `empty`=1.
- Send 0x11, then 0x22 with the stop bit forced low, then 0x33 0x44 0x55 0x66 -> `frame_err` pulse, and the single word received is 0x33445566.
- Drive a 3-clock low glitch on idle `sig` -> no state change, no `frame_err`, FIFO still empty.
- Assert `reset` during the 2nd byte of a word, with `sig` low at release -> no byte is captured until the line has been idle for 10 clocks. The next full word is received correctly.
- With `CYCLE_UART_IN_PARITY_EN`: send 0x01 with parity bit 0 -> `frame_err` pulse, byte dropped. Send 0x01 with parity 1 -> byte accepted.
